imsic_msi_dispatch: RTL and testbench



---
 rtl/imsic_msi_dispatch.sv | 116 +++++++++++
 tb/tb_imsic_msi_dispatch.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/imsic_msi_dispatch.sv
// IMSIC MSI dispatch: filters illegal MSIs, queues legal ones, and issues one-hot
// setipnum strobes to the target interrupt file, with drop/overflow diagnostics.
module imsic_msi_dispatch #(
  parameter  int NR_INTP_FILES   = 7,
  parameter  int NR_HARTS        = 1,
  parameter  int NR_SRC          = 256,
  parameter  int FIFO_DEPTH      = 4,
  localparam int NR_SRC_WIDTH    = $clog2(NR_SRC),
  localparam int NR_HARTS_WIDTH  = (NR_HARTS == 1) ? 1 : $clog2(NR_HARTS),
  localparam int INTP_FILE_WIDTH = $clog2(NR_INTP_FILES),
  localparam int MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH,
  localparam int NR_DEST         = NR_HARTS * NR_INTP_FILES
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [MSI_INFO_WIDTH-1:0]     i_msi_info,
  input  logic                          i_msi_info_vld,
  input  logic                          i_stall,
  input  logic                          i_clr_err,
  output logic [NR_SRC_WIDTH-1:0]       o_setipnum,
  output logic [NR_DEST-1:0]            o_setipnum_vld,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
  output logic                          o_overflow,
  output logic [7:0]                    o_drop_cnt
);

  localparam int DEST_W = (NR_DEST > 1) ? $clog2(NR_DEST) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [DEST_W-1:0]       dest;
    logic [NR_SRC_WIDTH-1:0] src;
  } entry_t;

  logic [NR_HARTS_WIDTH-1:0]  w_hart;
  logic [INTP_FILE_WIDTH-1:0] w_file;
  logic [NR_SRC_WIDTH-1:0]    w_src;
  logic [DEST_W-1:0]          w_dest;
  logic                       w_rise, w_legal, w_empty, w_full;
  logic                       w_push, w_pop, w_ovf, w_ill, w_err;
  entry_t                     w_head;

  logic                       r_vld_q;
  logic [AW:0]                r_wptr, r_rptr;
  entry_t                     r_mem [FIFO_DEPTH];
  logic [NR_SRC_WIDTH-1:0]    r_setipnum;
  logic [NR_DEST-1:0]         r_setipnum_vld;
  logic                       r_overflow;
  logic [7:0]                 r_drop_cnt;

  assign {w_hart, w_file, w_src} = i_msi_info;

  assign w_rise  = i_msi_info_vld & ~r_vld_q;
  assign w_legal = (w_src != '0) && (int'(w_file) < NR_INTP_FILES) && (int'(w_hart) < NR_HARTS);
  assign w_dest  = DEST_W'(int'(w_hart) * NR_INTP_FILES + int'(w_file));

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  assign w_pop  = ~w_empty & ~i_stall;
  assign w_push = w_rise & w_legal & (~w_full | w_pop);
  assign w_ovf  = w_rise & w_legal & w_full & ~w_pop;
  assign w_ill  = w_rise & ~w_legal;
  assign w_err  = w_ovf | w_ill;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= '{dest: w_dest, src: w_src};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_q        <= 1'b0;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_setipnum     <= '0;
      r_setipnum_vld <= '0;
    end else begin
      r_vld_q <= i_msi_info_vld;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr         <= r_rptr + 1'b1;
        r_setipnum     <= w_head.src;
        r_setipnum_vld <= NR_DEST'(1) << w_head.dest;
      end else begin
        r_setipnum_vld <= '0;
      end
    end
  end

  // A same-cycle error outranks the software clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_ovf)          r_overflow <= 1'b1;
      else if (i_clr_err) r_overflow <= 1'b0;

      if (w_err) begin
        if (i_clr_err)                r_drop_cnt <= 8'd1;
        else if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end else if (i_clr_err) begin
        r_drop_cnt <= '0;
      end
    end
  end

  assign o_setipnum     = r_setipnum;
  assign o_setipnum_vld = r_setipnum_vld;
  assign o_fifo_cnt     = r_wptr - r_rptr;
  assign o_overflow     = r_overflow;
  assign o_drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_imsic_msi_dispatch.sv
// Scoreboard bench for imsic_msi_dispatch: expected strobes are queued at stimulus time
// and matched, in order, against each strobe the DUT issues.
module tb_imsic_msi_dispatch;

  logic        clk = 1'b0;
  logic        rstn;
  logic [11:0] i_msi_info;
  logic        i_msi_info_vld;
  logic        i_stall;
  logic        i_clr_err;
  logic [7:0]  o_setipnum;
  logic [6:0]  o_setipnum_vld;
  logic [2:0]  o_fifo_cnt;
  logic        o_overflow;
  logic [7:0]  o_drop_cnt;

  imsic_msi_dispatch dut (
    .clk(clk), .rstn(rstn),
    .i_msi_info(i_msi_info), .i_msi_info_vld(i_msi_info_vld),
    .i_stall(i_stall), .i_clr_err(i_clr_err),
    .o_setipnum(o_setipnum), .o_setipnum_vld(o_setipnum_vld),
    .o_fifo_cnt(o_fifo_cnt), .o_overflow(o_overflow), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] vld;
    logic [7:0] src;
  } exp_t;

  exp_t sb[$];
  int   strobe_cyc[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rstn && o_setipnum_vld != '0) begin
      strobe_cyc.push_back(cyc);
      if (sb.size() == 0) chk("spurious_strobe", 32'(o_setipnum_vld), 32'h0);
      else begin
        e = sb.pop_front();
        chk("strobe_dest", 32'(o_setipnum_vld), 32'(e.vld));
        chk("strobe_src", 32'(o_setipnum), 32'(e.src));
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic exp_t mk(input logic h, input logic [2:0] f, input logic [7:0] s);
    exp_t e;
    logic [6:0] one;
    one   = 7'd1;
    e.vld = one << (int'(h) * 7 + int'(f));
    e.src = s;
    return e;
  endfunction

  // One message: valid high for one cycle, then one low cycle.
  task automatic send(input logic h, input logic [2:0] f, input logic [7:0] s, input bit accept);
    i_msi_info     = {h, f, s};
    i_msi_info_vld = 1'b1;
    if (accept) sb.push_back(mk(h, f, s));
    tick();
    i_msi_info_vld = 1'b0;
    tick();
  endtask

  initial begin
    int t0, n0;
    rstn = 1'b0; i_msi_info = '0; i_msi_info_vld = 1'b0; i_stall = 1'b0; i_clr_err = 1'b0;
    tick(3);
    chk("rst_setipnum", 32'(o_setipnum), 0);
    chk("rst_vld", 32'(o_setipnum_vld), 0);
    chk("rst_cnt", 32'(o_fifo_cnt), 0);
    chk("rst_ovf", 32'(o_overflow), 0);
    chk("rst_drop", 32'(o_drop_cnt), 0);
    rstn = 1'b1;
    tick(2);

    // Single message held high for 8 cycles.
    i_msi_info = {1'b0, 3'd1, 8'd5};
    i_msi_info_vld = 1'b1;
    sb.push_back(mk(1'b0, 3'd1, 8'd5));
    t0 = cyc;
    tick(8);
    i_msi_info_vld = 1'b0;
    tick(3);
    chk("single_count", 32'(strobe_cyc.size()), 1);
    if (strobe_cyc.size() > 0) chk("single_latency", 32'(strobe_cyc[0] - t0), 2);
    chk("single_drop", 32'(o_drop_cnt), 0);

    // Illegal: source 0, file 7, hart 1.
    send(1'b0, 3'd2, 8'd0, 1'b0);
    send(1'b0, 3'd7, 8'd3, 1'b0);
    tick(3);
    chk("illegal_drop2", 32'(o_drop_cnt), 2);
    chk("illegal_ovf", 32'(o_overflow), 0);
    send(1'b1, 3'd0, 8'd4, 1'b0);
    tick(2);
    chk("illegal_drop3", 32'(o_drop_cnt), 3);
    chk("illegal_nostrobe", 32'(strobe_cyc.size()), 1);

    // Clear coincident with an illegal rise: the error wins.
    i_msi_info = {1'b0, 3'd1, 8'd0};
    i_msi_info_vld = 1'b1;
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    i_msi_info_vld = 1'b0;
    chk("clr_vs_err_drop", 32'(o_drop_cnt), 1);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    chk("clr_drop", 32'(o_drop_cnt), 0);
    tick();

    // Overflow: five legal rises under stall into a 4-deep FIFO.
    i_stall = 1'b1;
    for (int s = 1; s <= 5; s++) send(1'b0, 3'd2, 8'(s), s <= 4);
    chk("ovf_cnt", 32'(o_fifo_cnt), 4);
    chk("ovf_flag", 32'(o_overflow), 1);
    chk("ovf_drop", 32'(o_drop_cnt), 1);

    // Full FIFO: release stall in the rise cycle, so the push rides the pop.
    n0 = strobe_cyc.size();
    i_msi_info = {1'b0, 3'd3, 8'd9};
    i_msi_info_vld = 1'b1;
    i_stall = 1'b0;
    sb.push_back(mk(1'b0, 3'd3, 8'd9));
    tick();
    i_msi_info_vld = 1'b0;
    tick(8);
    chk("burst_count", 32'(strobe_cyc.size() - n0), 5);
    if (strobe_cyc.size() - n0 == 5) chk("burst_back2back", 32'(strobe_cyc[n0 + 4] - strobe_cyc[n0]), 4);
    chk("burst_ovf", 32'(o_overflow), 1);
    chk("burst_drop", 32'(o_drop_cnt), 1);
    chk("burst_cnt", 32'(o_fifo_cnt), 0);

    // Reset with three entries queued.
    i_stall = 1'b1;
    for (int s = 20; s < 23; s++) send(1'b0, 3'd4, 8'(s), 1'b0);
    chk("pre_rst_cnt", 32'(o_fifo_cnt), 3);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_setipnum", 32'(o_setipnum), 0);
    chk("mid_rst_vld", 32'(o_setipnum_vld), 0);
    chk("mid_rst_cnt", 32'(o_fifo_cnt), 0);
    chk("mid_rst_ovf", 32'(o_overflow), 0);
    chk("mid_rst_drop", 32'(o_drop_cnt), 0);
    @(negedge clk);
    rstn = 1'b1;
    i_stall = 1'b0;
    n0 = strobe_cyc.size();
    tick(6);
    chk("post_rst_quiet", 32'(strobe_cyc.size() - n0), 0);
    send(1'b0, 3'd0, 8'h42, 1'b1);
    tick(4);
    chk("post_rst_strobe", 32'(strobe_cyc.size() - n0), 1);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
